// File: rtl/vram_rect_fill_if.sv
// AXI4 write-channel bundle for the rectangle fill engine.
// master: drives AW/W and BREADY; slave: drives the readies, BRESP and BVALID.
interface vram_rect_fill_if;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWLEN,
    output M_AXI_AWSIZE, M_AXI_AWBURST,
    output M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWLEN,
    input  M_AXI_AWSIZE, M_AXI_AWBURST,
    input  M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/vram_rect_fill.sv
// Solid-colour rectangle fill into the VRAM frame buffer over AXI4 writes.
// Ports: ACLK/ARESETN, START + rect/colour inputs, BUSY/DONE/ERR, m_axi master.
module vram_rect_fill #(
  parameter int H_WIDTH   = 640,
  parameter int V_HEIGHT  = 480,
  parameter int MAX_BURST = 16,
  parameter int COORD_W   = 11
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               START,
  input  logic [31:0]        BASE_ADDR,
  input  logic [COORD_W-1:0] RECT_X,
  input  logic [COORD_W-1:0] RECT_Y,
  input  logic [COORD_W-1:0] RECT_W,
  input  logic [COORD_W-1:0] RECT_H,
  input  logic [23:0]        COLOR,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  vram_rect_fill_if.master   m_axi
);
  localparam int CW = COORD_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AW, S_W, S_B, S_FIN
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0] r_x, r_xe, r_ye;
  logic [CW-1:0] r_col, r_row;
  logic [31:0]   r_base, r_awaddr, r_wdata;
  logic [7:0]    r_awlen;
  logic [8:0]    r_len, r_beat;
  logic          r_err, r_empty;

  logic [CW-1:0] w_xs, w_ys, w_xe, w_ye;
  logic          w_empty;
  logic [31:0]   w_pix, w_addr;
  logic [12:0]   w_rem, w_4k, w_len;
  logic [CW-1:0] w_ncol, w_nrow;
  logic          w_last, w_wlast;

  assign w_xs = {1'b0, RECT_X} + {1'b0, RECT_W};
  assign w_ys = {1'b0, RECT_Y} + {1'b0, RECT_H};
  assign w_xe = (w_xs > CW'(H_WIDTH)) ? CW'(H_WIDTH) : w_xs;
  assign w_ye = (w_ys > CW'(V_HEIGHT)) ? CW'(V_HEIGHT) : w_ys;
  assign w_empty = (RECT_W == '0) || (RECT_H == '0)
                || ({1'b0, RECT_X} >= CW'(H_WIDTH))
                || ({1'b0, RECT_Y} >= CW'(V_HEIGHT));

  assign w_pix  = 32'(r_row) * 32'(H_WIDTH) + 32'(r_col);
  assign w_addr = r_base + (w_pix << 2);
  assign w_rem  = 13'(r_xe) - 13'(r_col);
  // Beats left before the next 4 KB page.
  assign w_4k   = (13'h1000 - {1'b0, w_addr[11:0]}) >> 2;

  always_comb begin
    w_len = w_rem;
    if (w_len > 13'(MAX_BURST)) w_len = 13'(MAX_BURST);
    if (w_len > w_4k) w_len = w_4k;
  end

  assign w_ncol  = r_col + CW'(r_len);
  assign w_nrow  = r_row + CW'(1);
  assign w_last  = (r_beat == r_len - 9'd1);
  assign w_wlast = (r_state == S_W) && w_last;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (START) w_next = S_CALC;
      S_CALC: w_next = r_empty ? S_FIN : S_AW;
      S_AW:   if (m_axi.M_AXI_AWREADY) w_next = S_W;
      S_W:    if (m_axi.M_AXI_WREADY && w_last) w_next = S_B;
      S_B: begin
        if (m_axi.M_AXI_BVALID) begin
          if (w_ncol == r_xe && w_nrow == r_ye) w_next = S_FIN;
          else                                  w_next = S_CALC;
        end
      end
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_x     <= '0;
      r_xe    <= '0;
      r_ye    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_base  <= '0;
      r_wdata <= '0;
      r_awaddr <= '0;
      r_awlen <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            r_x     <= {1'b0, RECT_X};
            r_col   <= {1'b0, RECT_X};
            r_row   <= {1'b0, RECT_Y};
            r_xe    <= w_xe;
            r_ye    <= w_ye;
            r_base  <= BASE_ADDR;
            r_wdata <= {8'h00, COLOR};
            r_err   <= 1'b0;
            r_empty <= w_empty;
          end
        end
        S_CALC: begin
          r_awaddr <= w_addr;
          r_awlen  <= 8'(w_len - 13'd1);
          r_len    <= w_len[8:0];
          r_beat   <= '0;
        end
        S_W: begin
          if (m_axi.M_AXI_WREADY) r_beat <= r_beat + 9'd1;
        end
        S_B: begin
          if (m_axi.M_AXI_BVALID) begin
            if (m_axi.M_AXI_BRESP != 2'b00) r_err <= 1'b1;
            if (w_ncol == r_xe) begin
              r_col <= r_x;
              r_row <= w_nrow;
            end else begin
              r_col <= w_ncol;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWLEN   = r_awlen;
  assign m_axi.M_AXI_AWSIZE  = 3'b010;
  assign m_axi.M_AXI_AWBURST = 2'b01;
  assign m_axi.M_AXI_AWVALID = (r_state == S_AW);
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_WLAST   = w_wlast;
  assign m_axi.M_AXI_WVALID  = (r_state == S_W);
  assign m_axi.M_AXI_BREADY  = (r_state == S_B);

  assign BUSY = (r_state != S_IDLE) && (r_state != S_FIN);
  assign DONE = (r_state == S_FIN);
  assign ERR  = r_err;
endmodule
